// File: rtl/bus_pkg.sv
// Shared bus encodings and helpers for the frame-memory target.
package bus_pkg;

    typedef enum logic [2:0] {
        CmdIdle      = 3'b000,
        CmdRead      = 3'b010,
        CmdReadResp  = 3'b011,
        CmdWrite     = 3'b100,
        CmdWriteResp = 3'b101
    } cmd_e;

    typedef enum logic [2:0] {
        StIdle,
        StWrData,
        StWrBid,
        StWrResp,
        StRdBid,
        StRdData
    } state_e;

    localparam logic [1:0] RespPrioDefault = 2'b10;

    // Length code 0..3 maps to 1, 2, 4, 8 beats.
    function automatic logic [3:0] len_to_beats(input logic [1:0] len);
        return 4'd1 << len;
    endfunction

endpackage

// File: rtl/frame_mem_target_if.sv
// Request/response bus between an initiator and the frame-memory target.
interface frame_mem_target_if;

    logic        selin;
    logic [2:0]  cmdin;
    logic [1:0]  lenin;
    logic [31:0] addrdatain;
    logic        ackin;
    logic [1:0]  reqout;
    logic [1:0]  lenout;
    logic [31:0] addrdataout;
    logic [2:0]  cmdout;
    logic [3:0]  reqtar;
    logic        err;

    modport master (
        output selin, cmdin, lenin, addrdatain, ackin,
        input  reqout, lenout, addrdataout, cmdout, reqtar, err
    );

    modport slave (
        input  selin, cmdin, lenin, addrdatain, ackin,
        output reqout, lenout, addrdataout, cmdout, reqtar, err
    );

endinterface

// File: rtl/frame_ram.sv
// Frame storage: synchronous write, combinational read, never reset.
module frame_ram #(
    parameter int unsigned DEPTH = 256,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/frame_mem_target.sv
// Bus target that accepts burst writes/reads into a frame memory and bids to return responses.
module frame_mem_target
    import bus_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter logic [1:0]  RESP_PRIO = RespPrioDefault,
    parameter logic [3:0]  TAR_ID    = 4'd1
) (
    input logic               clk,
    input logic               reset,
    frame_mem_target_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [1:0]    len_q, len_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          err_q, err_d;

    logic [1:0]    reqout_q, reqout_d;
    logic [1:0]    lenout_q, lenout_d;
    logic [31:0]   addrdataout_q, addrdataout_d;
    cmd_e          cmdout_q, cmdout_d;
    logic [3:0]    reqtar_q, reqtar_d;

    logic          ram_we;
    logic [31:0]   ram_rdata;
    logic          ack_ok;
    logic          cmd_valid;

    frame_ram #(
        .DEPTH (DEPTH)
    ) u_frame_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (ptr_q),
        .wdata_i (bus.addrdatain),
        .raddr_i (ptr_q),
        .rdata_o (ram_rdata)
    );

    // A grant only counts while our bid is actually visible on the bus.
    assign ack_ok    = bus.ackin && (reqout_q != 2'b00);
    assign cmd_valid = bus.selin && (bus.cmdin != CmdIdle);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        reqout_d      = 2'b00;
        lenout_d      = 2'b00;
        addrdataout_d = 32'd0;
        cmdout_d      = CmdIdle;
        reqtar_d      = 4'd0;
        ram_we        = 1'b0;

        if (cmd_valid && (state_q != StIdle) && (state_q != StWrData)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.selin && (bus.cmdin == CmdRead)) begin
                    ptr_d   = bus.addrdatain[AW+1:2];
                    len_d   = bus.lenin;
                    cnt_d   = len_to_beats(bus.lenin);
                    state_d = StRdBid;
                end else if (bus.selin && (bus.cmdin == CmdWrite)) begin
                    ptr_d   = bus.addrdatain[AW+1:2];
                    len_d   = bus.lenin;
                    cnt_d   = len_to_beats(bus.lenin);
                    state_d = StWrData;
                end
            end

            StWrData: begin
                if (bus.selin) begin
                    ram_we = 1'b1;
                    ptr_d  = ptr_q + AW'(1);
                    cnt_d  = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = StWrBid;
                    end
                end
            end

            StWrBid: begin
                if (ack_ok) begin
                    cmdout_d = CmdWriteResp;
                    lenout_d = len_q;
                    reqtar_d = TAR_ID;
                    state_d  = StWrResp;
                end else begin
                    reqout_d = RESP_PRIO;
                end
            end

            StWrResp: begin
                state_d = StIdle;
            end

            StRdBid: begin
                if (ack_ok) begin
                    cmdout_d      = CmdReadResp;
                    lenout_d      = len_q;
                    reqtar_d      = TAR_ID;
                    addrdataout_d = ram_rdata;
                    ptr_d         = ptr_q + AW'(1);
                    cnt_d         = cnt_q - 4'd1;
                    state_d       = StRdData;
                end else begin
                    reqout_d = RESP_PRIO;
                end
            end

            StRdData: begin
                if (cnt_q != 4'd0) begin
                    cmdout_d      = CmdReadResp;
                    lenout_d      = len_q;
                    reqtar_d      = TAR_ID;
                    addrdataout_d = ram_rdata;
                    ptr_d         = ptr_q + AW'(1);
                    cnt_d         = cnt_q - 4'd1;
                end else begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            len_q         <= 2'b00;
            cnt_q         <= 4'd0;
            err_q         <= 1'b0;
            reqout_q      <= 2'b00;
            lenout_q      <= 2'b00;
            addrdataout_q <= 32'd0;
            cmdout_q      <= CmdIdle;
            reqtar_q      <= 4'd0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            reqout_q      <= reqout_d;
            lenout_q      <= lenout_d;
            addrdataout_q <= addrdataout_d;
            cmdout_q      <= cmdout_d;
            reqtar_q      <= reqtar_d;
        end
    end

    assign bus.reqout      = reqout_q;
    assign bus.lenout      = lenout_q;
    assign bus.addrdataout = addrdataout_q;
    assign bus.cmdout      = cmdout_q;
    assign bus.reqtar      = reqtar_q;
    assign bus.err         = err_q;

endmodule

// File: doc/frame_mem_target.md
FRAME_MEM_TARGET -- requirements
Module: frame_mem_target

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning frame-memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter RESP_PRIO, default 2'b10, meaning the bid level driven on reqout when responding.
REQ-003 SHALL have parameter TAR_ID, default 4'd1, meaning the initiator id driven on reqtar with responses.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 selin  input  1  target selected; qualifies cmdin/lenin/addrdatain.
REQ-007 cmdin  input  3  command: 000 IDLE, 010 READ, 011 READ_RESP, 100 WRITE, 101 WRITE_RESP.
REQ-008 lenin  input  2  burst length code: 00=1, 01=2, 10=4, 11=8 beats.
REQ-009 addrdatain  input  32  byte address on command beat, then write data beats.
REQ-010 ackin  input  1  bus grant for this target's pending bid.
REQ-011 reqout  output  2  bus bid level, 0 = no request.
REQ-012 lenout  output  2  burst length code of the response.
REQ-013 addrdataout  output  32  read data beats, or status word on write response.
REQ-014 cmdout  output  3  response command, same encoding as cmdin.
REQ-015 reqtar  output  4  destination id of the response.
REQ-016 err  output  1  sticky protocol-error flag.

Function
REQ-017 All outputs SHALL be registered; cmdout SHALL be IDLE and reqout, lenout, addrdataout, reqtar 0 whenever no response beat is driven.
REQ-018 FSM states SHALL be IDLE, WR_DATA, WR_BID, WR_RESP, RD_BID, RD_DATA.
REQ-019 IDLE: selin & READ SHALL latch word pointer addrdatain[log2(DEPTH)+1:2] and lenin, and go to RD_BID.
REQ-020 IDLE: selin & WRITE SHALL latch pointer and length and go to WR_DATA; any other cmdin, or selin low, SHALL be ignored.
REQ-021 WR_DATA: each cycle with selin high SHALL write addrdatain to mem[ptr], increment ptr, and count one beat; selin low SHALL stall without writing.
REQ-022 After the last write beat, the FSM SHALL go to WR_BID.
REQ-023 WR_BID/RD_BID: reqout SHALL equal RESP_PRIO from the cycle after entry until the cycle ackin is sampled high, then return to 0.
REQ-024 On ackin in WR_BID, the next cycle SHALL drive exactly one beat: cmdout=WRITE_RESP, lenout=latched len, addrdataout=0, reqtar=TAR_ID; the FSM then returns to IDLE.
REQ-025 On ackin in RD_BID, the next cycle SHALL drive the first beat: cmdout=READ_RESP, lenout=latched len, addrdataout=mem[ptr], reqtar=TAR_ID.
REQ-026 RD_DATA SHALL drive one beat per consecutive cycle, incrementing ptr, for exactly 1/2/4/8 beats, then IDLE with cmdout=IDLE the following cycle.
REQ-027 ptr SHALL wrap modulo DEPTH (DEPTH-1 -> 0) on both reads and writes.
REQ-028 selin with a non-IDLE cmdin in any state other than IDLE or WR_DATA SHALL be ignored and SHALL set err.
REQ-029 A read issued after a write response SHALL return the newly written data (no stale read).
REQ-030 ackin while reqout is 0 SHALL be ignored.

Reset
REQ-031 reset SHALL force IDLE, clear ptr, beat count, err and all outputs immediately, aborting any burst; memory contents SHALL be retained and not cleared.

Structure
REQ-032 Package bus_pkg SHALL hold the cmd enum typedef, the len-code-to-beat-count function, and the default RESP_PRIO constant.
REQ-033 Storage SHALL be a sub-module frame_ram (DEPTH x 32, synchronous write, combinational read).

Verification
REQ-034 WRITE len=10 at addr 0x10 with data 1,2,3,4; ackin 3 cycles later -> reqout=2'b10 until ack; one WRITE_RESP beat with data 0 and reqtar=1.
REQ-035 READ len=10 at addr 0x10 after REQ-034, ackin -> READ_RESP beats 1,2,3,4 on 4 consecutive cycles starting 1 cycle after ackin.
REQ-036 WRITE len=01 at word DEPTH-1 with data A,B; READ len=01 at DEPTH-1 -> A then B read from word 0 (wrap).
REQ-037 READ issued, then selin+WRITE while in RD_BID -> command ignored, err=1, read completes normally.
REQ-038 reset asserted mid RD_DATA on beat 2 of 8 -> outputs 0 asynchronously; after release, READ of the same address returns the original data.
REQ-039 WRITE len=00 with selin deasserted for 2 cycles during WR_DATA -> single write occurs only on the cycle selin returns high.
